// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions: widths, active-low strobe levels, FSM encoding and watchdog limit.
// The watchdog limit is only used when BUS_MASTER_TIMEOUT_EN is defined.
package bus_master_if_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 30;

    // Levels for the active-low bus strobes (bm_req_, bm_as_, bm_grnt_, bus_ready_)
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Ready-less cycles in ACCESS/WAIT before the transaction is aborted
    localparam int unsigned BUS_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StAccess = 2'd2,
        StWait   = 2'd3
    } bm_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Bus watchdog: counts ready-less cycles of a transaction and flags the edge that
// reaches the limit. Only instantiated when BUS_MASTER_TIMEOUT_EN is defined.
module bus_timeout_cnt
    import bus_master_if_pkg::*;
#(
    parameter int unsigned Cycles = BUS_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q;

    // Cleared on bus access start, advanced on every cycle still waiting for ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High on the edge that would bring the count to the limit
    assign expired = count && (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/bus_master_if.sv
// Single-outstanding bus master: takes a core request, arbitrates for the bus,
// issues a one-cycle address strobe and waits for the slave's ready.
// Optional watchdog abort is compiled in with BUS_MASTER_TIMEOUT_EN.
module bus_master_if
    import bus_master_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_rw,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wr_data,
    output logic                  core_busy,
    output logic                  core_ack,
    output logic                  core_err,
    output logic [DATA_WIDTH-1:0] core_rd_data,
    output logic                  bm_req_,
    input  logic                  bm_grnt_,
    output logic                  bm_as_,
    output logic                  bm_rw,
    output logic [ADDR_WIDTH-1:0] bm_addr,
    output logic [DATA_WIDTH-1:0] bm_wr_data,
    input  logic                  bus_ready_,
    input  logic [DATA_WIDTH-1:0] bus_rd_data
);

    bm_state_e             state_q;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  req_n_q;
    logic                  as_n_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  timeout_hit;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic wd_clear;
    logic wd_count;

    // Count restarts as the grant moves us into ACCESS; only ready-less cycles count
    assign wd_clear = (state_q == StReq) && (bm_grnt_ == ENABLE_);
    assign wd_count = ((state_q == StAccess) || (state_q == StWait)) &&
                      (bus_ready_ != ENABLE_);

    bus_timeout_cnt #(
        .Cycles (BUS_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Transaction FSM with registered bus strobes and core handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            req_n_q   <= DISABLE_;
            as_n_q    <= DISABLE_;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (core_req) begin
                        rw_q      <= core_rw;
                        addr_q    <= core_addr;
                        wr_data_q <= core_wr_data;
                        req_n_q   <= ENABLE_;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bm_grnt_ == ENABLE_) begin
                        as_n_q  <= ENABLE_;
                        state_q <= StAccess;
                    end
                end
                StAccess, StWait: begin
                    // Strobe lasts only the ACCESS cycle; grant is no longer watched here
                    as_n_q <= DISABLE_;
                    if (bus_ready_ == ENABLE_) begin
                        if (rw_q) begin
                            rd_data_q <= bus_rd_data;
                        end
                        req_n_q <= DISABLE_;
                        ack_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (timeout_hit) begin
                        req_n_q <= DISABLE_;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWait;
                    end
                end
            endcase
        end
    end

    assign core_busy    = (state_q != StIdle);
    assign core_ack     = ack_q;
    assign core_err     = err_q;
    assign core_rd_data = rd_data_q;
    assign bm_req_      = req_n_q;
    assign bm_as_       = as_n_q;
    assign bm_rw        = rw_q;
    assign bm_addr      = addr_q;
    assign bm_wr_data   = wr_data_q;

endmodule
